// File: rtl/decode_branch_stage_pkg.sv
// Shared encodings for the decode/branch stage: branch modes, forwarding
// selects and the default width of the packed control bundle.
package decode_branch_stage_pkg;

  localparam int CTRL_W_DEF = 16;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10,
    BR_LT   = 2'b11
  } br_mode_e;

  // The value 11 is an alias for the register-file path.
  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_MEM    = 2'b01,
    FWD_WB     = 2'b10,
    FWD_RF_ALT = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/branch_compare.sv
// Combinational branch-condition evaluator: beq, bne and signed blt.
module branch_compare
  import decode_branch_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [1:0]      mode,
  output logic            taken
);

  // Resolve the branch direction from the two forwarded operands.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    taken = 1'b0;
    case (br_mode_e'(mode))
      BR_EQ:   taken = (op1 == op2);
      BR_NE:   taken = (op1 != op2);
      BR_LT:   taken = ($signed(op1) < $signed(op2));
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_branch_stage.sv
// Decode-stage operand forwarding, early branch resolution and the ID/EX
// pipeline register, with mispredict redirect and saturating statistics.
module decode_branch_stage
  import decode_branch_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int PC_W         = 5,
  parameter int RA_W         = 5,
  parameter int CTRL_W       = CTRL_W_DEF,
  parameter int CNT_W        = 16,
  parameter int STALL_BUBBLE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [1:0]        id_br_mode,
  input  logic              id_pred_taken,
  input  logic [1:0]        fwd_sel1,
  input  logic [1:0]        fwd_sel2,
  input  logic [XLEN-1:0]   fwd_mem,
  input  logic [XLEN-1:0]   fwd_wb,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [RA_W-1:0]   ex_rd,
  output logic [XLEN-1:0]   ex_op1,
  output logic [XLEN-1:0]   ex_op2,
  output logic [XLEN-1:0]   ex_imm,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  logic [XLEN-1:0] op1, op2;
  logic            taken;
  logic            accept;
  logic            is_branch;
  logic            mispredict;
  logic [PC_W-1:0] target_pc;
  logic [PC_W-1:0] fall_pc;

  // Forwarding muxes: MEM and WB results override the register-file read.
  always_comb begin
    op1 = id_rd1;
    op2 = id_rd2;
    case (fwd_sel_e'(fwd_sel1))
      FWD_MEM: op1 = fwd_mem;
      FWD_WB:  op1 = fwd_wb;
      default: op1 = id_rd1;
    endcase
    case (fwd_sel_e'(fwd_sel2))
      FWD_MEM: op2 = fwd_mem;
      FWD_WB:  op2 = fwd_wb;
      default: op2 = id_rd2;
    endcase
  end

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .op1   (op1),
    .op2   (op2),
    .mode  (id_br_mode),
    .taken (taken)
  );

  // Only an unstalled, unflushed valid instruction may advance or count.
  assign accept     = id_valid & ~flush & ~stall;
  assign is_branch  = (id_br_mode != BR_NONE);
  assign mispredict = accept & is_branch & (taken != id_pred_taken);
  assign fall_pc    = id_pc + PC_W'(1);
  assign target_pc  = fall_pc + id_imm[PC_W-1:0];

  // ID/EX register: flush beats stall; stall either holds or bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_ctrl  <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_op1   <= '0;
      ex_op2   <= '0;
      ex_imm   <= '0;
    end else begin
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (stall) begin
        if (STALL_BUBBLE != 0) ex_valid <= 1'b0;
      end else begin
        ex_valid <= id_valid;
      end
      if (accept) begin
        ex_pc   <= id_pc;
        ex_ctrl <= id_ctrl;
        ex_rs1  <= id_rs1;
        ex_rs2  <= id_rs2;
        ex_rd   <= id_rd;
        ex_op1  <= op1;
        ex_op2  <= op2;
        ex_imm  <= id_imm;
      end
    end
  end

  // Redirect pulse, corrected fetch PC and saturating branch statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect       <= 1'b0;
      redirect_pc    <= '0;
      br_cnt         <= '0;
      mispredict_cnt <= '0;
    end else begin
      redirect <= mispredict;
      if (mispredict) begin
        redirect_pc <= taken ? target_pc : fall_pc;
        if (mispredict_cnt != {CNT_W{1'b1}}) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
      if (accept && is_branch && (br_cnt != {CNT_W{1'b1}})) begin
        br_cnt <= br_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_decode_branch_stage.sv
// Self-checking bench: two instances (hold and bubble stall policies) share
// stimulus; a behavioural model is compared against both every cycle.
module tb_decode_branch_stage;

  localparam int XLEN = 32, PC_W = 5, RA_W = 5, CTRL_W = 16, CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0, reset = 1'b1;
  logic stall, flush, id_valid, id_pred_taken;
  logic [PC_W-1:0] id_pc;
  logic [CTRL_W-1:0] id_ctrl;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_rd1, id_rd2, id_imm, fwd_mem, fwd_wb;
  logic [1:0] id_br_mode, fwd_sel1, fwd_sel2;

  logic ex_valid_a, ex_valid_b, redirect_a, redirect_b;
  logic [PC_W-1:0] ex_pc_a, ex_pc_b, rpc_a, rpc_b;
  logic [CTRL_W-1:0] ex_ctrl_a, ex_ctrl_b;
  logic [RA_W-1:0] rs1_a, rs1_b, rs2_a, rs2_b, rd_a, rd_b;
  logic [XLEN-1:0] op1_a, op1_b, op2_a, op2_b, imm_a, imm_b;
  logic [CNT_W-1:0] br_a, br_b, mis_a, mis_b;

  int n_checks = 0, n_pass = 0;
  bit tb_done = 1'b0;

  always #5 clk = ~clk;

  decode_branch_stage #(.XLEN(XLEN), .PC_W(PC_W), .RA_W(RA_W), .CTRL_W(CTRL_W),
                        .CNT_W(CNT_W), .STALL_BUBBLE(0)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_br_mode(id_br_mode),
    .id_pred_taken(id_pred_taken), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .fwd_mem(fwd_mem), .fwd_wb(fwd_wb), .ex_valid(ex_valid_a), .ex_pc(ex_pc_a),
    .ex_ctrl(ex_ctrl_a), .ex_rs1(rs1_a), .ex_rs2(rs2_a), .ex_rd(rd_a), .ex_op1(op1_a),
    .ex_op2(op2_a), .ex_imm(imm_a), .redirect(redirect_a), .redirect_pc(rpc_a),
    .br_cnt(br_a), .mispredict_cnt(mis_a));

  decode_branch_stage #(.XLEN(XLEN), .PC_W(PC_W), .RA_W(RA_W), .CTRL_W(CTRL_W),
                        .CNT_W(CNT_W), .STALL_BUBBLE(1)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_br_mode(id_br_mode),
    .id_pred_taken(id_pred_taken), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .fwd_mem(fwd_mem), .fwd_wb(fwd_wb), .ex_valid(ex_valid_b), .ex_pc(ex_pc_b),
    .ex_ctrl(ex_ctrl_b), .ex_rs1(rs1_b), .ex_rs2(rs2_b), .ex_rd(rd_b), .ex_op1(op1_b),
    .ex_op2(op2_b), .ex_imm(imm_b), .redirect(redirect_b), .redirect_pc(rpc_b),
    .br_cnt(br_b), .mispredict_cnt(mis_b));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  bit m_va, m_vb, m_redirect;
  int m_pc, m_ctrl, m_rs1, m_rs2, m_rd, m_rpc, m_br, m_mis;
  logic [31:0] m_op1, m_op2, m_imm;

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'd1) return fwd_mem;
    if (sel == 2'd2) return fwd_wb;
    return rf;
  endfunction

  function automatic bit br_taken(input int mode, input logic [31:0] a, input logic [31:0] b);
    if (mode == 1) return a == b;
    if (mode == 2) return a != b;
    if (mode == 3) return $signed(a) < $signed(b);
    return 1'b0;
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [31:0] a, b;
    bit t;
    if (!reset) begin
      m_va <= 0; m_vb <= 0; m_redirect <= 0; m_pc <= 0; m_ctrl <= 0; m_rs1 <= 0;
      m_rs2 <= 0; m_rd <= 0; m_rpc <= 0; m_br <= 0; m_mis <= 0;
      m_op1 <= 0; m_op2 <= 0; m_imm <= 0;
    end else begin
      a = pick(fwd_sel1, id_rd1);
      b = pick(fwd_sel2, id_rd2);
      t = br_taken(int'(id_br_mode), a, b);
      m_redirect <= 1'b0;
      if (flush) begin
        m_va <= 0; m_vb <= 0;
      end else if (stall) begin
        m_vb <= 0;
      end else if (!id_valid) begin
        m_va <= 0; m_vb <= 0;
      end else begin
        m_va <= 1; m_vb <= 1;
        m_pc <= id_pc; m_ctrl <= id_ctrl; m_rs1 <= id_rs1; m_rs2 <= id_rs2; m_rd <= id_rd;
        m_op1 <= a; m_op2 <= b; m_imm <= id_imm;
        if (id_br_mode != 0) begin
          if (m_br < CNT_MAX) m_br <= m_br + 1;
          if (t != id_pred_taken) begin
            m_redirect <= 1'b1;
            m_rpc <= t ? (int'(id_pc) + 1 + int'(id_imm[PC_W-1:0])) % (1 << PC_W)
                       : (int'(id_pc) + 1) % (1 << PC_W);
            if (m_mis < CNT_MAX) m_mis <= m_mis + 1;
          end
        end
      end
    end
  end

  // Compare both instances against the model away from the active edge.
  always @(negedge clk) begin
    if (reset && !tb_done) begin
      check("a.ex_valid", ex_valid_a, m_va);   check("b.ex_valid", ex_valid_b, m_vb);
      check("a.ex_pc", ex_pc_a, m_pc);         check("b.ex_pc", ex_pc_b, m_pc);
      check("a.ex_ctrl", ex_ctrl_a, m_ctrl);   check("b.ex_ctrl", ex_ctrl_b, m_ctrl);
      check("a.ex_rs1", rs1_a, m_rs1);         check("b.ex_rs1", rs1_b, m_rs1);
      check("a.ex_rs2", rs2_a, m_rs2);         check("b.ex_rs2", rs2_b, m_rs2);
      check("a.ex_rd", rd_a, m_rd);            check("b.ex_rd", rd_b, m_rd);
      check("a.ex_op1", op1_a, m_op1);         check("b.ex_op1", op1_b, m_op1);
      check("a.ex_op2", op2_a, m_op2);         check("b.ex_op2", op2_b, m_op2);
      check("a.ex_imm", imm_a, m_imm);         check("b.ex_imm", imm_b, m_imm);
      check("a.redirect", redirect_a, m_redirect); check("b.redirect", redirect_b, m_redirect);
      check("a.redirect_pc", rpc_a, m_rpc);    check("b.redirect_pc", rpc_b, m_rpc);
      check("a.br_cnt", br_a, m_br);           check("b.br_cnt", br_b, m_br);
      check("a.mis_cnt", mis_a, m_mis);        check("b.mis_cnt", mis_b, m_mis);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; stall = 0; flush = 0; id_br_mode = 0; id_pred_taken = 0;
    fwd_sel1 = 0; fwd_sel2 = 0;
  endtask

  task automatic drive(input int pc, input int imm, input int mode, input logic [31:0] rd1,
                       input logic [31:0] rd2, input int s1, input int s2, input bit pred);
    id_valid = 1; stall = 0; flush = 0;
    id_pc = PC_W'(pc); id_imm = 32'(imm); id_br_mode = 2'(mode);
    id_rd1 = rd1; id_rd2 = rd2; fwd_sel1 = 2'(s1); fwd_sel2 = 2'(s2); id_pred_taken = pred;
    id_ctrl = 16'hA000 | 16'(pc); id_rs1 = RA_W'(pc + 1); id_rs2 = RA_W'(pc + 2);
    id_rd = RA_W'(pc + 3);
  endtask

  initial begin
    idle();
    id_pc = 0; id_imm = 0; id_rd1 = 0; id_rd2 = 0; id_ctrl = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; fwd_mem = 0; fwd_wb = 0;
    #2 reset = 1'b0;
    step(); step();
    check("rst a.ex_valid", ex_valid_a, 0); check("rst b.ex_valid", ex_valid_b, 0);
    check("rst a.br_cnt", br_a, 0);         check("rst a.redirect_pc", rpc_a, 0);
    reset = 1'b1;

    // beq with MEM forward on op1: 7 == 7 taken, predicted not taken
    fwd_mem = 32'd7;
    drive(5, 3, 1, 32'd0, 32'd7, 1, 0, 0);
    step();
    check("beq redirect", redirect_a, 1); check("beq redirect_pc", rpc_a, 9);
    check("beq mis_cnt", mis_a, 1);       check("beq br_cnt", br_a, 1);
    idle();
    step();
    check("pulse ends", redirect_a, 0); check("rpc holds", rpc_a, 9);

    // bne wrap: 30 + 1 + 5 = 36 -> 4 modulo 32
    drive(30, 5, 2, 32'd1, 32'd2, 0, 0, 0);
    step();
    check("bne wrap redirect_pc", rpc_a, 4); check("bne redirect", redirect_b, 1);

    // blt signed: -1 < 1 taken, predicted taken -> no redirect
    drive(8, 4, 3, 32'hFFFF_FFFF, 32'd1, 0, 0, 1);
    step();
    check("blt no redirect", redirect_a, 0); check("blt mis_cnt", mis_a, 2);
    check("blt br_cnt", br_a, 3);

    // stall+flush on a mispredicting branch
    drive(12, 0, 0, 32'd0, 32'd0, 0, 0, 0);
    step();
    drive(20, 1, 1, 32'd9, 32'd9, 0, 0, 0);
    stall = 1; flush = 1;
    step();
    check("flush a.ex_valid", ex_valid_a, 0); check("flush b.ex_valid", ex_valid_b, 0);
    check("flush redirect", redirect_a, 0);   check("flush br_cnt", br_a, 3);

    // stall-only: hold vs bubble, then the held branch is accepted
    drive(17, 0, 0, 32'd1, 32'd2, 0, 0, 0);
    step();
    drive(3, 2, 1, 32'd4, 32'd4, 0, 0, 0);
    stall = 1;
    step();
    check("stall a.ex_valid", ex_valid_a, 1); check("stall a.ex_pc", ex_pc_a, 17);
    check("stall b.ex_valid", ex_valid_b, 0); check("stall b.ex_pc", ex_pc_b, 17);
    check("stall redirect", redirect_a, 0);   check("stall br_cnt", br_a, 3);
    stall = 0;
    step();
    check("unstall redirect", redirect_a, 1); check("unstall redirect_pc", rpc_a, 6);
    check("unstall mis_cnt", mis_a, 3);

    // forwarding: WB on op1, alias 11 on op2; then MEM on op1, WB on op2
    fwd_mem = 32'h77; fwd_wb = 32'h55;
    drive(9, 0, 0, 32'h11, 32'h66, 2, 3, 0);
    step();
    check("fwd wb op1", op1_a, 32'h55); check("fwd alias op2", op2_a, 32'h66);
    drive(10, 0, 0, 32'h11, 32'h66, 1, 2, 0);
    step();
    check("fwd mem op1", op1_b, 32'h77); check("fwd wb op2", op2_b, 32'h55);
    idle();
    step();
    check("idle a.ex_valid", ex_valid_a, 0);

    // 20 accepted mispredicts saturate the 4-bit counters
    for (int i = 0; i < 20; i++) begin
      drive(i, i, 1, 32'(i), 32'(i), 0, 0, 0);
      step();
    end
    check("sat mis_cnt", mis_a, 15); check("sat br_cnt", br_b, 15);
    check("sat redirect", redirect_a, 1);

    // asynchronous reset in the middle of the redirect pulse
    #2 reset = 1'b0;
    #1;
    check("async a.redirect", redirect_a, 0);  check("async b.redirect", redirect_b, 0);
    check("async a.rpc", rpc_a, 0);            check("async a.mis_cnt", mis_a, 0);
    check("async b.br_cnt", br_b, 0);          check("async a.ex_valid", ex_valid_a, 0);
    check("async a.ex_op1", op1_a, 0);         check("async b.ex_pc", ex_pc_b, 0);
    idle();
    step();
    reset = 1'b1;

    // updates resume on the first edge after release
    drive(1, 2, 2, 32'd5, 32'd6, 0, 0, 0);
    step();
    check("resume br_cnt", br_a, 1); check("resume redirect_pc", rpc_a, 4);
    idle();
    step();
    tb_done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
